// File: rtl/sdram_port_arbiter.sv
// Shares one 8-bit SDRAM controller among download, RAM-clear, Z80 and cassette ports.
// Registered single-access grant: IDLE -> ISSUE (strobe held until mem_done) -> DONE (ack pulse).
module sdram_port_arbiter #(
  parameter int ADDR_W       = 23,
  parameter int CAS_MAX_WAIT = 255
) (
  input  logic              clk_sys,
  input  logic              reset,
  input  logic              mem_init_done,
  input  logic              dl_req,
  input  logic              clr_req,
  input  logic              cpu_req,
  input  logic              cas_req,
  input  logic [ADDR_W-1:0] dl_addr,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [ADDR_W-1:0] cas_addr,
  input  logic [7:0]        dl_din,
  input  logic [7:0]        clr_din,
  input  logic [7:0]        cpu_din,
  input  logic              cpu_we,
  input  logic              cas_window,
  output logic              dl_ack,
  output logic              clr_ack,
  output logic              cpu_ack,
  output logic              cas_ack,
  output logic [7:0]        rdata,
  output logic              mem_rd,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout,
  input  logic              mem_done,
  output logic [3:0]        grant,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, DONE} state_t;

  localparam logic [7:0] CAS_LIMIT = 8'(CAS_MAX_WAIT);

  state_t            state;
  logic [7:0]        cas_wait;
  logic [3:0]        ack;
  logic [3:0]        win;
  logic [ADDR_W-1:0] sel_addr;
  logic [7:0]        sel_din;
  logic              sel_we;
  logic              promoted;
  logic              cas_elig;

  assign dl_ack  = ack[0];
  assign clr_ack = ack[1];
  assign cpu_ack = ack[2];
  assign cas_ack = ack[3];

  // A promoted cassette request jumps ahead of the CPU but never ahead of dl/clr.
  always_comb begin
    win      = 4'b0000;
    sel_addr = '0;
    sel_din  = 8'h00;
    sel_we   = 1'b0;
    promoted = (cas_wait >= CAS_LIMIT);
    cas_elig = cas_req && (cas_window || promoted);
    if (dl_req) begin
      win = 4'b0001; sel_addr = dl_addr; sel_din = dl_din; sel_we = 1'b1;
    end else if (clr_req) begin
      win = 4'b0010; sel_addr = clr_addr; sel_din = clr_din; sel_we = 1'b1;
    end else if (cas_elig && promoted) begin
      win = 4'b1000; sel_addr = cas_addr;
    end else if (cpu_req) begin
      win = 4'b0100; sel_addr = cpu_addr; sel_din = cpu_din; sel_we = cpu_we;
    end else if (cas_elig) begin
      win = 4'b1000; sel_addr = cas_addr;
    end
  end

  always_ff @(posedge clk_sys) begin
    if (reset) begin
      state    <= IDLE;
      ack      <= 4'b0000;
      mem_rd   <= 1'b0;
      mem_we   <= 1'b0;
      mem_addr <= '0;
      mem_din  <= 8'h00;
      rdata    <= 8'h00;
      grant    <= 4'b0000;
      busy     <= 1'b0;
    end else begin
      ack <= 4'b0000;
      case (state)
        IDLE: begin
          if (mem_init_done && (win != 4'b0000)) begin
            grant    <= win;
            mem_addr <= sel_addr;
            mem_din  <= sel_din;
            mem_we   <= sel_we;
            mem_rd   <= !sel_we;
            busy     <= 1'b1;
            state    <= ISSUE;
          end
        end
        ISSUE: begin
          if (mem_done) begin
            if (mem_rd) rdata <= mem_dout;
            mem_rd <= 1'b0;
            mem_we <= 1'b0;
            ack    <= grant;
            state  <= DONE;
          end
        end
        DONE: begin
          grant <= 4'b0000;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Counts only cycles where a cassette request is actually waiting.
  always_ff @(posedge clk_sys) begin
    if (reset) begin
      cas_wait <= 8'h00;
    end else if (!cas_req || grant[3] || (state == IDLE && mem_init_done && win[3])) begin
      cas_wait <= 8'h00;
    end else if (cas_wait != 8'hFF) begin
      cas_wait <= cas_wait + 8'h01;
    end
  end

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Randomized bench: transaction-level model predicts each grant; a negedge monitor checks issues and acks.
module tb_sdram_port_arbiter;
  localparam int AW  = 23;
  localparam int CMW = 8;

  logic          clk_sys = 1'b0;
  logic          reset, mem_init_done, cpu_we, cas_window;
  logic          dl_req, clr_req, cpu_req, cas_req;
  logic [AW-1:0] dl_addr, clr_addr, cpu_addr, cas_addr;
  logic [7:0]    dl_din, clr_din, cpu_din;
  logic          dl_ack, clr_ack, cpu_ack, cas_ack;
  logic [7:0]    rdata, mem_din, mem_dout;
  logic          mem_rd, mem_we, mem_done, busy;
  logic [AW-1:0] mem_addr;
  logic [3:0]    grant;

  logic [3:0]    rq;
  logic [AW-1:0] pa [4];
  logic [7:0]    pd [4];
  logic          pwe;

  assign dl_req = rq[0];  assign clr_req = rq[1];  assign cpu_req = rq[2];  assign cas_req = rq[3];
  assign dl_addr = pa[0]; assign clr_addr = pa[1]; assign cpu_addr = pa[2]; assign cas_addr = pa[3];
  assign dl_din = pd[0];  assign clr_din = pd[1];  assign cpu_din = pd[2];  assign cpu_we = pwe;

  sdram_port_arbiter #(.ADDR_W(AW), .CAS_MAX_WAIT(CMW)) dut (
    .clk_sys(clk_sys), .reset(reset), .mem_init_done(mem_init_done),
    .dl_req(dl_req), .clr_req(clr_req), .cpu_req(cpu_req), .cas_req(cas_req),
    .dl_addr(dl_addr), .clr_addr(clr_addr), .cpu_addr(cpu_addr), .cas_addr(cas_addr),
    .dl_din(dl_din), .clr_din(clr_din), .cpu_din(cpu_din), .cpu_we(cpu_we),
    .cas_window(cas_window),
    .dl_ack(dl_ack), .clr_ack(clr_ack), .cpu_ack(cpu_ack), .cas_ack(cas_ack),
    .rdata(rdata), .mem_rd(mem_rd), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_done(mem_done),
    .grant(grant), .busy(busy)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d got=%0h expected=%0h", name, cyc, act, exp);
    end
  endtask

  typedef struct { int cyc; int port; logic [AW-1:0] addr; logic [7:0] din; logic we; } iss_t;
  typedef struct { int cyc; int port; logic [7:0] rd; } ack_t;
  iss_t iss_q[$];
  ack_t ack_q[$];

  // Monitor: every strobe rise must match the next predicted grant; every ack the next predicted completion.
  logic          m_ps = 1'b0;
  logic [AW-1:0] m_paddr;
  logic [9:0]    m_pctl;
  initial begin
    iss_t e;
    ack_t a;
    logic strobe;
    logic [3:0] acks;
    forever begin
      @(negedge clk_sys);
      strobe = mem_rd | mem_we;
      acks   = {cas_ack, cpu_ack, clr_ack, dl_ack};
      if (strobe && !m_ps) begin
        if (iss_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_issue cyc=%0d grant=%0h required=no access", cyc, grant);
        end else begin
          e = iss_q.pop_front();
          chk("issue_cycle", cyc, e.cyc);
          chk("issue_grant", {28'd0, grant}, 32'd1 << e.port);
          chk("issue_addr", {9'd0, mem_addr}, {9'd0, e.addr});
          chk("issue_dir", {30'd0, mem_rd, mem_we}, e.we ? 32'd1 : 32'd2);
          if (e.we) chk("issue_din", {24'd0, mem_din}, {24'd0, e.din});
          chk("issue_busy", {31'd0, busy}, 32'd1);
        end
      end else if (strobe && m_ps) begin
        chk("hold_addr", {9'd0, mem_addr}, {9'd0, m_paddr});
        chk("hold_ctl", {22'd0, mem_rd, mem_we, mem_din}, {22'd0, m_pctl});
      end
      if (acks != 4'b0000) begin
        if (ack_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_ack cyc=%0d acks=%0h required=none", cyc, acks);
        end else begin
          a = ack_q.pop_front();
          chk("ack_cycle", cyc, a.cyc);
          chk("ack_port", {28'd0, acks}, 32'd1 << a.port);
          chk("ack_rdata", {24'd0, rdata}, {24'd0, a.rd});
          chk("ack_strobes_low", {30'd0, mem_rd, mem_we}, 32'd0);
          chk("ack_after_strobe", {31'd0, m_ps}, 32'd1);
        end
      end
      m_ps    = strobe;
      m_paddr = mem_addr;
      m_pctl  = {mem_rd, mem_we, mem_din};
    end
  end

  // Driver plus reference model: requests, controller responses and predicted schedule.
  initial begin
    int prob [4];
    logic [3:0] dropped;
    logic m_busy, post_reset, we, in_issue, prom;
    int m_owner, m_gc, m_lat, m_cw, nrst, win, k;
    logic [7:0] m_d, m_rdata, exp_rd;
    prob = '{30, 20, 60, 25};
    reset = 1'b1; mem_init_done = 1'b0; cas_window = 1'b0;
    mem_done = 1'b0; mem_dout = 8'h00; rq = 4'b0000; pwe = 1'b0;
    for (int p = 0; p < 4; p++) begin pa[p] = '0; pd[p] = 8'h00; end
    m_busy = 1'b0; post_reset = 1'b0; m_owner = 0; m_gc = 0; m_lat = 1;
    m_cw = 0; nrst = 0; m_d = 8'h00; m_rdata = 8'h00;
    repeat (3) @(posedge clk_sys);
    #1;
    chk("rst_acks", {28'd0, cas_ack, cpu_ack, clr_ack, dl_ack}, 32'd0);
    chk("rst_strobes", {30'd0, mem_rd, mem_we}, 32'd0);
    chk("rst_addr", {9'd0, mem_addr}, 32'd0);
    chk("rst_din", {24'd0, mem_din}, 32'd0);
    chk("rst_rdata", {24'd0, rdata}, 32'd0);
    chk("rst_grant", {28'd0, grant}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);

    for (int i = 0; i < 8000; i++) begin
      if (i >= 4000 && !m_busy && rq == 4'b0000) break;
      k = cyc;
      reset = 1'b0;
      if (post_reset) begin
        chk("abort_strobes", {30'd0, mem_rd, mem_we}, 32'd0);
        chk("abort_grant", {28'd0, grant}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        post_reset = 1'b0;
      end
      dropped = 4'b0000;
      if (m_busy && k == m_gc + m_lat + 2) begin
        m_busy = 1'b0; rq[m_owner] = 1'b0; dropped[m_owner] = 1'b1;
      end
      if (i < 4000) begin
        for (int p = 0; p < 4; p++)
          if (!rq[p] && !dropped[p] && $urandom_range(0, 99) < prob[p]) begin
            rq[p] = 1'b1; pa[p] = AW'($urandom); pd[p] = 8'($urandom);
            if (p == 2) pwe = 1'($urandom);
          end
      end
      if (m_busy && $urandom_range(0, 3) == 0) begin
        pa[m_owner] = AW'($urandom); pd[m_owner] = 8'($urandom);
        if (m_owner == 2) pwe = ~pwe;
      end
      cas_window = ($urandom_range(0, 9) == 0);
      if (i < 20 || i >= 4000) mem_init_done = (i >= 20);
      else if (mem_init_done) mem_init_done = ($urandom_range(0, 49) != 0);
      else mem_init_done = ($urandom_range(0, 4) == 0);
      mem_dout = 8'($urandom);
      mem_done = 1'b0;
      in_issue = m_busy && k >= m_gc + 1 && k <= m_gc + m_lat;
      if (m_busy && k == m_gc + m_lat) begin
        mem_done = 1'b1; mem_dout = m_d;
      end else if (!in_issue && $urandom_range(0, 7) == 0) begin
        mem_done = 1'b1;
      end
      if (in_issue && k >= m_gc + 2 && nrst < 6 && $urandom_range(0, 29) == 0) begin
        reset = 1'b1; mem_done = 1'b0; nrst++;
        m_busy = 1'b0; ack_q.delete(); m_rdata = 8'h00; post_reset = 1'b1;
      end
      if (!reset && !m_busy && mem_init_done) begin
        prom = (m_cw >= CMW);
        win = -1;
        if (rq[0]) win = 0;
        else if (rq[1]) win = 1;
        else if (rq[3] && prom) win = 3;
        else if (rq[2]) win = 2;
        else if (rq[3] && cas_window) win = 3;
        if (win >= 0) begin
          m_busy = 1'b1; m_owner = win; m_gc = k;
          m_lat = $urandom_range(1, 5); m_d = 8'($urandom);
          we = (win < 2) ? 1'b1 : ((win == 2) ? pwe : 1'b0);
          iss_q.push_back('{cyc: k + 1, port: win, addr: pa[win], din: pd[win], we: we});
          exp_rd = we ? m_rdata : m_d;
          m_rdata = exp_rd;
          ack_q.push_back('{cyc: k + m_lat + 1, port: win, rd: exp_rd});
        end
      end
      if (reset || !rq[3] || (m_busy && m_owner == 3)) m_cw = 0;
      else if (m_cw < 255) m_cw++;
      @(posedge clk_sys);
      #1;
    end

    chk("drain_done", {27'd0, m_busy, rq}, 32'd0);
    repeat (3) @(posedge clk_sys);
    #1;
    chk("issue_queue_empty", iss_q.size(), 32'd0);
    chk("ack_queue_empty", ack_q.size(), 32'd0);
    chk("final_busy", {31'd0, busy}, 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
